// File: rtl/iob_mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO PHY responder:
// FSM encoding, opcodes, register addresses and register reset values.
package iob_mdio_pkg;

  // Frame-tracking states, one per MDIO frame field
  typedef enum logic [2:0] {
    ST_PREAMBLE = 3'd0,
    ST_ST2      = 3'd1,
    ST_OP       = 3'd2,
    ST_PHYAD    = 3'd3,
    ST_REGAD    = 3'd4,
    ST_TA       = 3'd5,
    ST_DATA     = 3'd6
  } mdio_state_e;

  // Clause-22 opcodes (the ST field is 01 and is checked separately)
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  // Register addresses served by the responder
  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_PHYID2 = 5'd3;
  localparam logic [4:0] REG_ANAR   = 5'd4;
  localparam logic [4:0] REG_ANLPAR = 5'd5;

  // Register reset / base values
  localparam logic [15:0] BMCR_RST = 16'h1100;
  localparam logic [15:0] BMSR_RST = 16'h7869;
  localparam logic [15:0] ANAR_RST = 16'h01E1;

  // Frame field lengths, expressed as the last bit index of each field
  localparam logic [4:0] OP_LAST    = 5'd1;
  localparam logic [4:0] ADDR_LAST  = 5'd4;
  localparam logic [4:0] TA_LAST    = 5'd1;
  localparam logic [4:0] DATA_LAST  = 5'd15;

endpackage

// File: rtl/iob_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module iob_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous input into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/iob_mdio_phy_responder.sv
// Clause-22 MDIO PHY responder. MDC/MDIO are oversampled in the clk domain;
// frames addressed to PHY_ADDR are decoded and served from a small register
// file (BMCR, BMSR, PHYID1/2, ANAR, ANLPAR).
module iob_mdio_phy_responder
  import iob_mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHYID1       = 16'h0022,
  parameter logic [15:0] PHYID2       = 16'h1619,
  parameter int unsigned PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        link_up_i,
  output logic [15:0] bmcr_o,
  output logic        soft_rst_o,
  output logic        frame_done_o
);

  localparam int unsigned     PRE_W   = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_MIN);

  // Synchronised pins and edge detect
  logic w_mdc_s;
  logic w_mdio_s;
  logic r_mdc_d;
  logic w_mdc_rise;

  // Frame tracking
  mdio_state_e      r_state;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [4:0]       r_bit_cnt;
  logic             r_op0;
  logic             r_is_rd;
  logic [3:0]       r_phyad;
  logic             r_match;
  logic [4:0]       r_regad;
  logic [15:0]      r_shift;

  // Register file and registered outputs
  logic [15:0] r_bmcr;
  logic [15:0] r_anar;
  logic        r_mdio;
  logic        r_mdio_oe;
  logic        r_soft_rst;
  logic        r_frame_done;

  // Combinational helpers
  logic [1:0]  w_op;
  logic [4:0]  w_phyad_full;
  logic [4:0]  w_regad_full;
  logic [15:0] w_rd_data;
  logic [15:0] w_wdata;
  logic        w_serve_rd;

  iob_sync2 u_sync_mdc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (mdc_i),
    .o_q   (w_mdc_s)
  );

  iob_sync2 u_sync_mdio (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (mdio_i),
    .o_q   (w_mdio_s)
  );

  // Delay the synced MDC by one clk for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_d <= 1'b0;
    end else begin
      r_mdc_d <= w_mdc_s;
    end
  end

  assign w_mdc_rise   = w_mdc_s & ~r_mdc_d;
  assign w_op         = {r_op0, w_mdio_s};
  assign w_phyad_full = {r_phyad, w_mdio_s};
  assign w_regad_full = {r_regad[3:0], w_mdio_s};
  assign w_wdata      = {r_shift[14:0], w_mdio_s};
  assign w_serve_rd   = r_is_rd & r_match;

  // Read mux, evaluated on the register address as it completes
  always_comb begin
    w_rd_data = '0;
    case (w_regad_full)
      REG_BMCR:   w_rd_data = r_bmcr;
      REG_BMSR:   w_rd_data = BMSR_RST | {13'd0, link_up_i, 2'd0};
      REG_PHYID1: w_rd_data = PHYID1;
      REG_PHYID2: w_rd_data = PHYID2;
      REG_ANAR:   w_rd_data = r_anar;
      REG_ANLPAR: w_rd_data = link_up_i ? r_anar : '0;
      default:    w_rd_data = '0;
    endcase
  end

  // Frame FSM, read driver, write commit and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_PREAMBLE;
      r_pre_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_op0        <= 1'b0;
      r_is_rd      <= 1'b0;
      r_phyad      <= '0;
      r_match      <= 1'b0;
      r_regad      <= '0;
      r_shift      <= '0;
      r_bmcr       <= BMCR_RST;
      r_anar       <= ANAR_RST;
      r_mdio       <= 1'b0;
      r_mdio_oe    <= 1'b0;
      r_soft_rst   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_soft_rst   <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_mdc_rise) begin
        case (r_state)
          ST_PREAMBLE: begin
            if (w_mdio_s) begin
              if (r_pre_cnt != PRE_MAX) begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
              end
            end else begin
              // First bit of ST only counts after a full preamble
              if (r_pre_cnt == PRE_MAX) begin
                r_state <= ST_ST2;
              end
              r_pre_cnt <= '0;
            end
          end

          ST_ST2: begin
            if (w_mdio_s) begin
              r_state   <= ST_OP;
              r_bit_cnt <= '0;
            end else begin
              r_state <= ST_PREAMBLE;
            end
          end

          ST_OP: begin
            if (r_bit_cnt != OP_LAST) begin
              r_op0     <= w_mdio_s;
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end else if (w_op == MDIO_OP_RD || w_op == MDIO_OP_WR) begin
              r_is_rd   <= (w_op == MDIO_OP_RD);
              r_state   <= ST_PHYAD;
              r_bit_cnt <= '0;
            end else begin
              r_state <= ST_PREAMBLE;
            end
          end

          ST_PHYAD: begin
            r_phyad <= w_phyad_full[3:0];
            if (r_bit_cnt == ADDR_LAST) begin
              r_match   <= (w_phyad_full == PHY_ADDR);
              r_state   <= ST_REGAD;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          ST_REGAD: begin
            r_regad <= w_regad_full;
            if (r_bit_cnt == ADDR_LAST) begin
              r_shift   <= w_rd_data;
              r_state   <= ST_TA;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          ST_TA: begin
            if (r_bit_cnt != TA_LAST) begin
              if (w_serve_rd) begin
                r_mdio_oe <= 1'b1;
                r_mdio    <= 1'b0;
              end
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end else begin
              // Data leads the master's sample by one bit: D15 goes out here
              if (w_serve_rd) begin
                r_mdio  <= r_shift[15];
                r_shift <= {r_shift[14:0], 1'b0};
              end
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end

          ST_DATA: begin
            if (r_is_rd) begin
              if (r_match) begin
                if (r_bit_cnt == DATA_LAST) begin
                  r_mdio_oe <= 1'b0;
                  r_mdio    <= 1'b0;
                end else begin
                  r_mdio  <= r_shift[15];
                  r_shift <= {r_shift[14:0], 1'b0};
                end
              end
            end else begin
              r_shift <= w_wdata;
            end

            if (r_bit_cnt == DATA_LAST) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= '0;
              if (r_match) begin
                r_frame_done <= 1'b1;
                if (!r_is_rd) begin
                  if (r_regad == REG_BMCR) begin
                    // Soft reset wins over the written word; bit 15 is never stored
                    if (w_wdata[15]) begin
                      r_soft_rst <= 1'b1;
                      r_bmcr     <= BMCR_RST;
                      r_anar     <= ANAR_RST;
                    end else begin
                      r_bmcr <= w_wdata;
                    end
                  end else if (r_regad == REG_ANAR) begin
                    r_anar <= w_wdata;
                  end
                end
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          default: begin
            r_state   <= ST_PREAMBLE;
            r_pre_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign mdio_o       = r_mdio;
  assign mdio_oe_o    = r_mdio_oe;
  assign bmcr_o       = r_bmcr;
  assign soft_rst_o   = r_soft_rst;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_iob_mdio_phy_responder.sv
// Directed bench for iob_mdio_phy_responder: acts as the MIIM master,
// bit-bangs MDC/MDIO and checks responses against hand-computed values.
module tb_iob_mdio_phy_responder;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_BAD = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        mdc_i;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic        link_up_i;
  logic [15:0] bmcr_o;
  logic        soft_rst_o;
  logic        frame_done_o;

  int n_cmp;
  int n_bad;
  int n_done;
  int n_soft;
  int n_oe;

  iob_mdio_phy_responder #(
    .PHY_ADDR     (5'd1),
    .PHYID1       (16'h0022),
    .PHYID2       (16'h1619),
    .PREAMBLE_MIN (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdc_i        (mdc_i),
    .mdio_i       (mdio_i),
    .mdio_o       (mdio_o),
    .mdio_oe_o    (mdio_oe_o),
    .link_up_i    (link_up_i),
    .bmcr_o       (bmcr_o),
    .soft_rst_o   (soft_rst_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse / drive counters, sampled on the inactive edge
  initial begin
    n_done = 0;
    n_soft = 0;
    n_oe   = 0;
  end
  always @(negedge clk) begin
    if (frame_done_o) n_done = n_done + 1;
    if (soft_rst_o)   n_soft = n_soft + 1;
    if (mdio_oe_o)    n_oe   = n_oe + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MDC bit: drive while MDC is low, sample the PHY just before the rise
  task automatic mdc_bit(input logic b, output logic so, output logic soe);
    mdio_i = b;
    #70;
    so  = mdio_o;
    soe = mdio_oe_o;
    #10 mdc_i = 1'b1;
    #80 mdc_i = 1'b0;
  endtask

  // Frame after preamble: ST(0-1) OP(2-3) PHYAD(4-8) REGAD(9-13) TA(14-15) DATA(16-31)
  task automatic mdio_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd, input int pre_len, input int nbits,
                            output logic [15:0] rd, output logic ta2_o, output logic ta2_oe,
                            output logic oe_end);
    logic [31:0] fr;
    logic so, soe;
    fr = {2'b01, op, phy, rg, (op == OP_WR) ? 2'b10 : 2'b11, (op == OP_WR) ? wd : 16'hFFFF};
    rd = '0;
    ta2_o = 1'b1;
    ta2_oe = 1'b0;
    for (int i = 0; i < pre_len; i++) mdc_bit(1'b1, so, soe);
    for (int i = 0; i < nbits; i++) begin
      mdc_bit(fr[31-i], so, soe);
      if (i == 15) begin
        ta2_o  = so;
        ta2_oe = soe;
      end
      if (i >= 16) rd[31-i] = so;
    end
    oe_end = mdio_oe_o;
  endtask

  task automatic rd_reg(input logic [4:0] phy, input logic [4:0] rg, output logic [15:0] rd);
    logic t_o, t_oe, oe_end;
    mdio_frame(OP_RD, phy, rg, 16'h0000, 32, 32, rd, t_o, t_oe, oe_end);
  endtask

  task automatic wr_reg(input logic [4:0] rg, input logic [15:0] wd);
    logic [15:0] rd;
    logic t_o, t_oe, oe_end;
    mdio_frame(OP_WR, 5'd1, rg, wd, 32, 32, rd, t_o, t_oe, oe_end);
  endtask

  initial begin
    logic [15:0] rd;
    logic t_o, t_oe, oe_end;
    int d0, s0, o0;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    mdc_i = 1'b0;
    mdio_i = 1'b1;
    link_up_i = 1'b0;

    #20;
    check("rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    check("rst_mdio", {31'd0, mdio_o}, 32'd0);
    check("rst_bmcr", {16'd0, bmcr_o}, 32'h1100);
    check("rst_soft", {31'd0, soft_rst_o}, 32'd0);
    check("rst_done", {31'd0, frame_done_o}, 32'd0);
    #10 rst_n = 1'b1;
    #20;

    // Read PHYID1
    d0 = n_done;
    mdio_frame(OP_RD, 5'd1, 5'd2, 16'h0000, 32, 32, rd, t_o, t_oe, oe_end);
    check("id1_ta2_o", {31'd0, t_o}, 32'd0);
    check("id1_ta2_oe", {31'd0, t_oe}, 32'd1);
    check("id1_data", {16'd0, rd}, 32'h0022);
    check("id1_oe_end", {31'd0, oe_end}, 32'd0);
    check("id1_done", n_done - d0, 1);

    // Read PHYID2
    rd_reg(5'd1, 5'd3, rd);
    check("id2_data", {16'd0, rd}, 32'h1619);

    // ANAR write / readback, ANLPAR mirror with link up
    d0 = n_done;
    wr_reg(5'd4, 16'h0061);
    check("wr_done", n_done - d0, 1);
    rd_reg(5'd1, 5'd4, rd);
    check("anar_rd", {16'd0, rd}, 32'h0061);
    rd_reg(5'd1, 5'd5, rd);
    check("anlpar_down", {16'd0, rd}, 32'h0000);
    link_up_i = 1'b1;
    rd_reg(5'd1, 5'd5, rd);
    check("anlpar_up", {16'd0, rd}, 32'h0061);

    // BMCR write, then soft reset
    wr_reg(5'd0, 16'h5140);
    check("bmcr_wr", {16'd0, bmcr_o}, 32'h5140);
    rd_reg(5'd1, 5'd0, rd);
    check("bmcr_rd", {16'd0, rd}, 32'h5140);
    s0 = n_soft;
    wr_reg(5'd0, 16'h8000);
    check("soft_pulse", n_soft - s0, 1);
    check("soft_bmcr", {16'd0, bmcr_o}, 32'h1100);
    rd_reg(5'd1, 5'd4, rd);
    check("soft_anar", {16'd0, rd}, 32'h01E1);

    // Unmapped register reads 0, writes ignored
    wr_reg(5'd9, 16'hBEEF);
    rd_reg(5'd1, 5'd9, rd);
    check("unmapped", {16'd0, rd}, 32'h0000);

    // Wrong PHY address: no drive, no done; next frame served
    d0 = n_done;
    o0 = n_oe;
    rd_reg(5'd2, 5'd2, rd);
    check("mis_oe", n_oe - o0, 0);
    check("mis_done", n_done - d0, 0);
    rd_reg(5'd1, 5'd3, rd);
    check("after_mis", {16'd0, rd}, 32'h1619);

    // Short preamble: frame ignored
    d0 = n_done;
    o0 = n_oe;
    mdio_frame(OP_RD, 5'd1, 5'd2, 16'h0000, 31, 32, rd, t_o, t_oe, oe_end);
    check("short_oe", n_oe - o0, 0);
    check("short_done", n_done - d0, 0);

    // Bad opcode aborts, next BMSR read served
    d0 = n_done;
    o0 = n_oe;
    mdio_frame(OP_BAD, 5'd1, 5'd1, 16'h0000, 32, 32, rd, t_o, t_oe, oe_end);
    check("badop_oe", n_oe - o0, 0);
    check("badop_done", n_done - d0, 0);
    rd_reg(5'd1, 5'd1, rd);
    check("bmsr_up", {16'd0, rd}, 32'h786D);
    link_up_i = 1'b0;
    rd_reg(5'd1, 5'd1, rd);
    check("bmsr_down", {16'd0, rd}, 32'h7869);

    // Reset during read bit D8 releases the line at once
    wr_reg(5'd0, 16'h0140);
    check("pre_rst_bmcr", {16'd0, bmcr_o}, 32'h0140);
    mdio_frame(OP_RD, 5'd1, 5'd0, 16'h0000, 32, 23, rd, t_o, t_oe, oe_end);
    check("mid_oe", {31'd0, mdio_oe_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", {31'd0, mdio_oe_o}, 32'd0);
    #9;
    check("rst_mid_bmcr", {16'd0, bmcr_o}, 32'h1100);
    #20 rst_n = 1'b1;
    #20;
    d0 = n_done;
    rd_reg(5'd1, 5'd0, rd);
    check("post_rst_rd", {16'd0, rd}, 32'h1100);
    check("post_rst_done", n_done - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
